// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first WIDTH-bit subtractor a - b with a done strobe
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sb, res, sa_nxt, sb_nxt, res_nxt, diff_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             brw, brw_nxt, bo_nxt;
    logic             x, y, hd1, hb1, d, hb2, brw_new;

    // two chained half-subtractor cells; their borrows OR into the carried borrow
    assign x       = sa[0];
    assign y       = sb[0];
    assign hd1     = x ^ y;
    assign hb1     = ~x & y;
    assign d       = hd1 ^ brw;
    assign hb2     = ~hd1 & brw;
    assign brw_new = hb1 | hb2;

    // next-state and datapath update; everything holds unless the state acts on it
    always_comb begin
        state_nxt = state;
        sa_nxt    = sa;
        sb_nxt    = sb;
        res_nxt   = res;
        brw_nxt   = brw;
        cnt_nxt   = cnt;
        diff_nxt  = diff;
        bo_nxt    = borrow_out;
        case (state)
            IDLE: if (start) begin
                sa_nxt    = a;
                sb_nxt    = b;
                brw_nxt   = 1'b0;
                cnt_nxt   = '0;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                res_nxt = {d, res[WIDTH-1:1]};
                sa_nxt  = sa >> 1;
                sb_nxt  = sb >> 1;
                brw_nxt = brw_new;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    diff_nxt  = {d, res[WIDTH-1:1]};
                    bo_nxt    = brw_new;
                    cnt_nxt   = cnt;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            sa         <= sa_nxt;
            sb         <= sb_nxt;
            res        <= res_nxt;
            brw        <= brw_nxt;
            cnt        <= cnt_nxt;
            diff       <= diff_nxt;
            borrow_out <= bo_nxt;
            busy       <= state_nxt != IDLE;
            done       <= state_nxt == DONE;
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and random checks of the bit-serial subtractor
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, borrow_out;
    logic [7:0] diff;
    int         errors = 0;
    int         checks = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    // launch one op and return the number of edges after the accepting edge until done
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, output int e);
        @(negedge clk);
        a = ia;
        b = ib;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        e = 0;
        while (!done && e < 40) begin
            @(negedge clk);
            e++;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, done, borrow_out, diff} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got busy=%b done=%b bo=%b diff=%h want all 0", busy, done, borrow_out, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, borrow_out, diff} !== 11'd0) begin
            errors++;
            $display("FAIL reset_release: got busy=%b done=%b bo=%b diff=%h want all 0", busy, done, borrow_out, diff);
        end
    endtask

    task automatic test_basic();
        int e;
        run_op(8'd5, 8'd3, e);
        checks++;
        if (e !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges after start edge want 8", e);
        end
        checks++;
        if ({borrow_out, diff} !== 9'h002) begin
            errors++;
            $display("FAIL basic_result: got bo=%b diff=%h want bo=0 diff=02", borrow_out, diff);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'h02) begin
            errors++;
            $display("FAIL basic_after: got done=%b busy=%b diff=%h want 0 0 02", done, busy, diff);
        end
    endtask

    task automatic test_borrow();
        int n = 0;
        logic [8:0] r = '0;
        @(negedge clk);
        a = 8'd3;
        b = 8'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (busy && n < 40) begin
            if (done) r = {borrow_out, diff};
            n++;
            @(negedge clk);
        end
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL borrow_busy_cycles: got %0d want 9", n);
        end
        checks++;
        if (r !== 9'h1FE) begin
            errors++;
            $display("FAIL borrow_result: got %h want 1fe", r);
        end
    endtask

    task automatic test_edges();
        int e;
        run_op(8'h00, 8'hFF, e);
        checks++;
        if (e !== 8 || {borrow_out, diff} !== 9'h101) begin
            errors++;
            $display("FAIL edge_00_ff: got e=%0d bo=%b diff=%h want 8 1 01", e, borrow_out, diff);
        end
        run_op(8'hA5, 8'hA5, e);
        checks++;
        if (e !== 8 || {borrow_out, diff} !== 9'h000) begin
            errors++;
            $display("FAIL edge_equal: got e=%0d bo=%b diff=%h want 8 0 00", e, borrow_out, diff);
        end
        run_op(8'hFF, 8'h00, e);
        checks++;
        if (e !== 8 || {borrow_out, diff} !== 9'h0FF) begin
            errors++;
            $display("FAIL edge_ff_00: got e=%0d bo=%b diff=%h want 8 0 ff", e, borrow_out, diff);
        end
    endtask

    task automatic test_start_held();
        int dones = 0;
        int e = 0;
        @(negedge clk);
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (i == 3) begin
                a = 8'hEE;
                b = 8'h77;
            end
        end
        checks++;
        if (dones !== 1 || done !== 1'b1 || {borrow_out, diff} !== 9'h00F) begin
            errors++;
            $display("FAIL held_first: got dones=%0d done=%b bo=%b diff=%h want 1 1 0 0f", dones, done, borrow_out, diff);
        end
        a = 8'h20;
        b = 8'h30;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_idle_gap: got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL held_reaccept: got busy=%b want 1", busy);
        end
        start = 1'b0;
        while (!done && e < 40) begin
            @(negedge clk);
            e++;
        end
        checks++;
        if (e !== 8 || {borrow_out, diff} !== 9'h1F0) begin
            errors++;
            $display("FAIL held_second: got e=%0d bo=%b diff=%h want 8 1 f0", e, borrow_out, diff);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        int e;
        @(negedge clk);
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, borrow_out, diff} !== 11'd0) begin
            errors++;
            $display("FAIL abort_clear: got busy=%b done=%b bo=%b diff=%h want all 0", busy, done, borrow_out, diff);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        checks++;
        if (dones !== 0 || diff !== 8'h00) begin
            errors++;
            $display("FAIL abort_quiet: got activity=%0d diff=%h want 0 00", dones, diff);
        end
        run_op(8'h33, 8'h11, e);
        checks++;
        if (e !== 8 || {borrow_out, diff} !== 9'h022) begin
            errors++;
            $display("FAIL abort_recover: got e=%0d bo=%b diff=%h want 8 0 22", e, borrow_out, diff);
        end
    endtask

    task automatic test_random();
        int e;
        int bad = 0;
        logic [7:0] ra, rb;
        logic [8:0] exp_v;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            exp_v = {1'b0, ra} - {1'b0, rb};
            run_op(ra, rb, e);
            checks++;
            if (e !== 8 || {borrow_out, diff} !== exp_v) begin
                errors++;
                bad++;
                if (bad < 10)
                    $display("FAIL random %h-%h: got e=%0d bo=%b diff=%h want 8 %h", ra, rb, e, borrow_out, diff, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_edges();
        test_start_held();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
